// File: rtl/instr_encoder_loader_pkg.sv
// Shared instruction-set constants for the encoder/loader and the controller decode:
// mnemonic enum, opcodes, funct codes, field positions and word-packing helpers.
package instr_encoder_loader_pkg;

   typedef enum logic [4:0] {
      MN_SLL   = 5'd0,  MN_SRL  = 5'd1,  MN_SRA     = 5'd2,  MN_ADD  = 5'd3,
      MN_ADDU  = 5'd4,  MN_SUB  = 5'd5,  MN_AND     = 5'd6,  MN_OR   = 5'd7,
      MN_NOR   = 5'd8,  MN_SLT  = 5'd9,  MN_SLTU    = 5'd10, MN_JR   = 5'd11,
      MN_SYSCALL = 5'd12, MN_J  = 5'd13, MN_JAL     = 5'd14, MN_BEQ  = 5'd15,
      MN_BNE   = 5'd16, MN_ADDI = 5'd17, MN_ADDIU   = 5'd18, MN_SLTI = 5'd19,
      MN_ANDI  = 5'd20, MN_ORI  = 5'd21, MN_LW      = 5'd22, MN_SW   = 5'd23
   } mnem_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'd0,  OP_J    = 6'd2,  OP_JAL  = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4,  OP_BNE  = 6'd5,  OP_ADDI = 6'd8;
   localparam logic [5:0] OP_ADDIU = 6'd9,  OP_SLTI = 6'd10, OP_ANDI = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13, OP_LW   = 6'd35, OP_SW   = 6'd43;

   localparam logic [5:0] FN_SLL  = 6'd0,  FN_SRL  = 6'd2,  FN_SRA  = 6'd3;
   localparam logic [5:0] FN_JR   = 6'd8,  FN_SYSCALL = 6'd12, FN_ADD = 6'd32;
   localparam logic [5:0] FN_ADDU = 6'd33, FN_SUB  = 6'd34, FN_AND  = 6'd36;
   localparam logic [5:0] FN_OR   = 6'd37, FN_NOR  = 6'd39, FN_SLT  = 6'd42;
   localparam logic [5:0] FN_SLTU = 6'd43;

   localparam int OP_HI = 31, OP_LO = 26, RS_HI = 25, RS_LO = 21;
   localparam int RT_HI = 20, RT_LO = 16, RD_HI = 15, RD_LO = 11;
   localparam int SH_HI = 10, SH_LO = 6,  FN_HI = 5,  FN_LO = 0;
   localparam int IMM_HI = 15, IMM_LO = 0, TGT_HI = 25, TGT_LO = 0;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
      logic [31:0] w;
      w = 32'd0;
      w[OP_HI:OP_LO] = OP_RTYPE;
      w[RS_HI:RS_LO] = rs;
      w[RT_HI:RT_LO] = rt;
      w[RD_HI:RD_LO] = rd;
      w[SH_HI:SH_LO] = shamt;
      w[FN_HI:FN_LO] = funct;
      return w;
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      logic [31:0] w;
      w = 32'd0;
      w[OP_HI:OP_LO]   = op;
      w[RS_HI:RS_LO]   = rs;
      w[RT_HI:RT_LO]   = rt;
      w[IMM_HI:IMM_LO] = imm;
      return w;
   endfunction

   function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
      logic [31:0] w;
      w = 32'd0;
      w[OP_HI:OP_LO]   = op;
      w[TGT_HI:TGT_LO] = target;
      return w;
   endfunction

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational packer: mnemonic plus operand fields -> 32-bit word and legality flag.
// Fields a format does not use are forced to zero so they never leak into the word.
module instr_pack
   import instr_encoder_loader_pkg::*;
(
   input  logic [4:0]  mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);

   // Shifts drop rs, other R-types drop shamt; JR keeps only rs, SYSCALL only its funct.
   always_comb begin
      word  = 32'd0;
      legal = 1'b1;
      case (mnem)
         MN_SLL:     word = r_word(5'd0, rt, rd, shamt, FN_SLL);
         MN_SRL:     word = r_word(5'd0, rt, rd, shamt, FN_SRL);
         MN_SRA:     word = r_word(5'd0, rt, rd, shamt, FN_SRA);
         MN_ADD:     word = r_word(rs, rt, rd, 5'd0, FN_ADD);
         MN_ADDU:    word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
         MN_SUB:     word = r_word(rs, rt, rd, 5'd0, FN_SUB);
         MN_AND:     word = r_word(rs, rt, rd, 5'd0, FN_AND);
         MN_OR:      word = r_word(rs, rt, rd, 5'd0, FN_OR);
         MN_NOR:     word = r_word(rs, rt, rd, 5'd0, FN_NOR);
         MN_SLT:     word = r_word(rs, rt, rd, 5'd0, FN_SLT);
         MN_SLTU:    word = r_word(rs, rt, rd, 5'd0, FN_SLTU);
         MN_JR:      word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
         MN_SYSCALL: word = r_word(5'd0, 5'd0, 5'd0, 5'd0, FN_SYSCALL);
         MN_J:       word = j_word(OP_J, target);
         MN_JAL:     word = j_word(OP_JAL, target);
         MN_BEQ:     word = i_word(OP_BEQ, rs, rt, imm);
         MN_BNE:     word = i_word(OP_BNE, rs, rt, imm);
         MN_ADDI:    word = i_word(OP_ADDI, rs, rt, imm);
         MN_ADDIU:   word = i_word(OP_ADDIU, rs, rt, imm);
         MN_SLTI:    word = i_word(OP_SLTI, rs, rt, imm);
         MN_ANDI:    word = i_word(OP_ANDI, rs, rt, imm);
         MN_ORI:     word = i_word(OP_ORI, rs, rt, imm);
         MN_LW:      word = i_word(OP_LW, rs, rt, imm);
         MN_SW:      word = i_word(OP_SW, rs, rt, imm);
         default: begin
            word  = 32'd0;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams symbolic instructions into IMEM: valid/ready intake, one-cycle write pipeline,
// sequential word addressing from 0 within a start..finish session.
module instr_encoder_loader
   import instr_encoder_loader_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_mnem,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              err_illegal
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   state_e              state_r, state_nx_s;
   logic [ADDR_W:0]     count_r;
   logic                we_r, err_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [31:0]         wdata_r, word_s;
   logic                legal_s, ready_s, xfer_s, open_s;

   instr_pack u_pack (
      .mnem   (in_mnem),
      .rs     (in_rs),
      .rt     (in_rt),
      .rd     (in_rd),
      .shamt  (in_shamt),
      .imm    (in_imm),
      .target (in_target),
      .word   (word_s),
      .legal  (legal_s)
   );

   assign ready_s = (state_r == ST_LOAD) && (count_r < DEPTH_C);
   assign xfer_s  = in_valid && ready_s;
   assign open_s  = start && (state_r != ST_LOAD);

   // Session FSM: start is honoured only outside LOAD; a full loader waits for finish.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nx_s = ST_LOAD;
            else       state_nx_s = ST_IDLE;
         end
         ST_LOAD: begin
            if (finish) state_nx_s = ST_DONE;
            else        state_nx_s = ST_LOAD;
         end
         ST_DONE: begin
            if (start) state_nx_s = ST_LOAD;
            else       state_nx_s = ST_DONE;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Write pipeline: address is the pre-increment count; illegal requests only set the flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         count_r <= '0;
         we_r    <= 1'b0;
         addr_r  <= '0;
         wdata_r <= 32'd0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         we_r    <= xfer_s && legal_s;
         if (xfer_s && legal_s) begin
            addr_r  <= count_r[ADDR_W-1:0];
            wdata_r <= word_s;
            count_r <= count_r + (ADDR_W + 1)'(1);
         end else if (open_s) begin
            count_r <= '0;
         end
         if (open_s)                     err_r <= 1'b0;
         else if (xfer_s && !legal_s)    err_r <= 1'b1;
      end
   end

   assign in_ready    = ready_s;
   assign imem_we     = we_r;
   assign imem_addr   = addr_r;
   assign imem_wdata  = wdata_r;
   assign count       = count_r;
   assign busy        = (state_r == ST_LOAD);
   assign done        = (state_r == ST_DONE);
   assign err_illegal = err_r;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader with a 4-word depth so the full condition is reachable.
module tb_instr_encoder_loader;

   localparam int DEPTH = 4;
   localparam int AW    = 10;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, finish = 1'b0, in_valid = 1'b0;
   logic [4:0]    in_mnem = 5'd0, in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_shamt = 5'd0;
   logic [15:0]   in_imm = 16'd0;
   logic [25:0]   in_target = 26'd0;
   logic          in_ready, imem_we, busy, done, err_illegal;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   count;

   instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_imm(in_imm), .in_target(in_target),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .count(count), .busy(busy), .done(done), .err_illegal(err_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0, failures = 0;
   int   wr_cnt = 0;
   bit   mon_en = 1'b0;
   int   m_state = 0;   // 0 idle, 1 load, 2 done
   int   m_cnt = 0;
   bit   m_err = 1'b0;
   bit   m_rdy, m_xfer;
   logic [32:0] m_enc;
   exp_t m_item;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference encoder built from opcode/funct tables and shifts.
   function automatic logic [32:0] enc(input logic [4:0] m, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [15:0] imm,
                                       input logic [25:0] tgt);
      int rfn[8];
      int iop[9];
      int mi;
      logic [31:0] w;
      rfn = '{32, 33, 34, 36, 37, 39, 42, 43};
      iop = '{4, 5, 8, 9, 10, 12, 13, 35, 43};
      mi  = int'(m);
      if (mi <= 2)
         w = (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'((mi == 0) ? 0 : mi + 1);
      else if (mi <= 10)
         w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(rfn[mi-3]);
      else if (mi == 11)
         w = (32'(rs) << 21) | 32'd8;
      else if (mi == 12)
         w = 32'd12;
      else if (mi <= 14)
         w = (32'(mi - 11) << 26) | 32'(tgt);
      else if (mi <= 23)
         w = (32'(iop[mi-15]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
      else
         return {1'b0, 32'd0};
      return {1'b1, w};
   endfunction

   // Monitor: compare writes against the scoreboard, check status against the model, then advance it.
   always @(negedge clk) begin
      if (mon_en) begin
         if (imem_we) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
               check_val("unexpected_we", 64'(imem_we), 64'd0);
            end else begin
               m_item = sb_q.pop_front();
               check_val("wr_addr", 64'(imem_addr), 64'(m_item.addr));
               check_val("wr_data", 64'(imem_wdata), 64'(m_item.data));
            end
         end
         m_rdy = (m_state == 1) && (m_cnt < DEPTH);
         check_val("in_ready", 64'(in_ready), 64'(m_rdy));
         check_val("count", 64'(count), 64'(m_cnt));
         check_val("busy", 64'(busy), 64'(m_state == 1));
         check_val("done", 64'(done), 64'(m_state == 2));
         check_val("err_illegal", 64'(err_illegal), 64'(m_err));
         m_xfer = in_valid && m_rdy;
         m_enc  = enc(in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
         if (rst) begin
            m_state = 0; m_cnt = 0; m_err = 1'b0;
         end else if (m_state != 1 && start) begin
            m_state = 1; m_cnt = 0; m_err = 1'b0;
         end else if (m_state == 1) begin
            if (m_xfer) begin
               if (m_enc[32]) begin
                  m_item.addr = AW'(m_cnt);
                  m_item.data = m_enc[31:0];
                  sb_q.push_back(m_item);
                  m_cnt++;
               end else begin
                  m_err = 1'b1;
               end
            end
            if (finish) m_state = 2;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_finish();
      finish = 1'b1;
      tick();
      finish = 1'b0;
   endtask

   task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
      in_valid = 1'b1; in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd;
      in_shamt = sh; in_imm = imm; in_target = tgt;
      tick();
   endtask

   task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [31:0] d);
      check_val({tag, "_we"}, 64'(imem_we), 64'd1);
      check_val({tag, "_addr"}, 64'(imem_addr), 64'(a));
      check_val({tag, "_data"}, 64'(imem_wdata), 64'(d));
   endtask

   int w0;

   initial begin
      repeat (3) tick();
      check_val("rst_in_ready", 64'(in_ready), 64'd0);
      check_val("rst_we", 64'(imem_we), 64'd0);
      check_val("rst_addr", 64'(imem_addr), 64'd0);
      check_val("rst_wdata", 64'(imem_wdata), 64'd0);
      check_val("rst_count", 64'(count), 64'd0);
      check_val("rst_err", 64'(err_illegal), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      tick();

      // ADD rs=1 rt=2 rd=3
      pulse_start();
      send(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
      in_valid = 1'b0;
      check_write("add", 10'd0, 32'h00221820);
      check_val("add_count", 64'(count), 64'd1);
      tick();
      check_val("add_we_single", 64'(imem_we), 64'd0);
      pulse_finish();

      // Back-to-back LW, J, SLL, then SYSCALL together with finish
      pulse_start();
      send(5'd22, 5'd29, 5'd8, 5'd17, 5'd9, 16'd4, 26'h3ffffff);
      check_write("lw", 10'd0, 32'h8FA80004);
      send(5'd13, 5'd5, 5'd6, 5'd7, 5'd3, 16'hffff, 26'h0100000);
      check_write("j", 10'd1, 32'h08100000);
      send(5'd0, 5'd7, 5'd5, 5'd4, 5'd2, 16'hffff, 26'h3ffffff);
      check_write("sll", 10'd2, 32'h00052080);
      finish = 1'b1;
      send(5'd12, 5'd31, 5'd31, 5'd31, 5'd31, 16'hffff, 26'h3ffffff);
      finish = 1'b0;
      in_valid = 1'b0;
      check_write("syscall", 10'd3, 32'h0000000C);
      check_val("fin_done", 64'(done), 64'd1);
      tick();

      // Illegal mnemonic: handshake, no write, sticky flag until next start
      pulse_start();
      send(5'd27, 5'd1, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h155);
      check_val("ill_we", 64'(imem_we), 64'd0);
      check_val("ill_count", 64'(count), 64'd0);
      check_val("ill_err", 64'(err_illegal), 64'd1);
      send(5'd5, 5'd9, 5'd10, 5'd11, 5'd0, 16'd0, 26'd0);
      in_valid = 1'b0;
      check_val("ill_err_hold", 64'(err_illegal), 64'd1);
      check_write("sub_after_ill", 10'd0, 32'h012A5822);
      pulse_finish();
      check_val("ill_err_done", 64'(err_illegal), 64'd1);
      pulse_start();
      check_val("ill_err_clear", 64'(err_illegal), 64'd0);

      // Six requests into a four-word loader
      w0 = wr_cnt;
      for (int i = 0; i < 6; i++) begin
         send(5'($urandom_range(0, 23)), 5'($urandom), 5'($urandom), 5'($urandom),
              5'($urandom), 16'($urandom), 26'($urandom));
      end
      in_valid = 1'b0;
      tick();
      check_val("full_in_ready", 64'(in_ready), 64'd0);
      check_val("full_count", 64'(count), 64'd4);
      check_val("full_busy", 64'(busy), 64'd1);
      check_val("full_writes", 64'(wr_cnt - w0), 64'd4);
      pulse_finish();
      check_val("full_done", 64'(done), 64'd1);
      check_val("full_not_busy", 64'(busy), 64'd0);

      // Reset arriving with a transfer drops the write
      pulse_start();
      rst = 1'b1;
      send(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0);
      in_valid = 1'b0;
      check_val("mid_rst_we", 64'(imem_we), 64'd0);
      check_val("mid_rst_addr", 64'(imem_addr), 64'd0);
      check_val("mid_rst_wdata", 64'(imem_wdata), 64'd0);
      check_val("mid_rst_count", 64'(count), 64'd0);
      check_val("mid_rst_busy", 64'(busy), 64'd0);
      check_val("mid_rst_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      repeat (3) tick();
      check_val("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
